// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit, port and FSM definitions for the mesh router
package noc_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_S    = 2;
  localparam int PORT_W    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  localparam int TYPE_HI   = 17;
  localparam int TYPE_LO   = 16;
  localparam int DEST_X_LO = 14;
  localparam int DEST_Y_LO = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic is_head(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
  endfunction

  function automatic logic is_last(input logic [1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/xy_route_compute.sv
// rtl/xy_route_compute.sv - dimension-ordered (X then Y) output port selection
module xy_route_compute
  import noc_pkg::*;
#(
  parameter int COORD_WIDTH = 2
) (
  input  logic [COORD_WIDTH-1:0] dest_x,
  input  logic [COORD_WIDTH-1:0] dest_y,
  input  logic [COORD_WIDTH-1:0] x_pos,
  input  logic [COORD_WIDTH-1:0] y_pos,
  output logic [NUM_PORTS-1:0]   dir
);

  always_comb begin
    dir = '0;
    if (dest_x > x_pos)      dir[PORT_E] = 1'b1;
    else if (dest_x < x_pos) dir[PORT_W] = 1'b1;
    else if (dest_y > y_pos) dir[PORT_S] = 1'b1;
    else if (dest_y < y_pos) dir[PORT_N] = 1'b1;
    else                     dir[PORT_L] = 1'b1;
  end

endmodule

// File: rtl/input_port_controller.sv
// rtl/input_port_controller.sv - per-input-port route, request and flit streaming stage
module input_port_controller
  import noc_pkg::*;
#(
  parameter int WIDTH       = 18,
  parameter int COORD_WIDTH = 2,
  parameter int X_POS       = 0,
  parameter int Y_POS       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_read,
  output logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] grant,
  input  logic                 out_full,
  output logic [WIDTH-1:0]     flit_out,
  output logic                 flit_valid,
  output logic                 drop_err
);

  state_t                 state, state_next;
  logic [NUM_PORTS-1:0]   req_next;
  logic [NUM_PORTS-1:0]   route;
  logic [1:0]             flit_type;
  logic                   granted;

  assign flit_type = fifo_data[TYPE_HI:TYPE_LO];
  assign granted   = |(grant & req);

  xy_route_compute #(
    .COORD_WIDTH(COORD_WIDTH)
  ) u_route (
    .dest_x (fifo_data[DEST_X_LO +: COORD_WIDTH]),
    .dest_y (fifo_data[DEST_Y_LO +: COORD_WIDTH]),
    .x_pos  (COORD_WIDTH'(X_POS)),
    .y_pos  (COORD_WIDTH'(Y_POS)),
    .dir    (route)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      req   <= '0;
    end else begin
      state <= state_next;
      req   <= req_next;
    end
  end

  // Strobes are held low while rst is high so nothing is popped during reset.
  always_comb begin
    state_next = state;
    req_next   = req;
    fifo_read  = 1'b0;
    flit_valid = 1'b0;
    drop_err   = 1'b0;
    flit_out   = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (is_head(flit_type)) begin
              req_next   = route;
              state_next = ST_REQ;
            end else begin
              fifo_read = 1'b1;
              drop_err  = 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (granted) state_next = ST_SEND;
        end
        ST_SEND: begin
          if (granted && !fifo_empty && !out_full) begin
            fifo_read  = 1'b1;
            flit_valid = 1'b1;
            flit_out   = fifo_data;
            if (is_last(flit_type)) begin
              state_next = ST_IDLE;
              req_next   = '0;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
// tb/tb_input_port_controller.sv - self-checking bench for input_port_controller at router (1,1)
module tb_input_port_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [17:0] fifo_data;
  logic        fifo_read;
  logic [4:0]  req;
  logic [4:0]  grant;
  logic        out_full;
  logic [17:0] flit_out;
  logic        flit_valid;
  logic        drop_err;

  always #5 clk = ~clk;

  input_port_controller #(
    .WIDTH(18), .COORD_WIDTH(2), .X_POS(1), .Y_POS(1)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .req(req), .grant(grant), .out_full(out_full),
    .flit_out(flit_out), .flit_valid(flit_valid), .drop_err(drop_err)
  );

  // FIFO contents, plus what must happen to each entry when it leaves
  logic [17:0] fifo_q[$];
  bit          cls_q[$];
  logic [4:0]  route_q[$];
  bit          mdl_in_pkt = 1'b0;
  logic [4:0]  mdl_route  = '0;
  logic [17:0] gen_q[$];

  int pop_cnt   = 0;
  int pops_done = 0;
  int n_cmp     = 0;
  int n_err     = 0;

  typedef struct {
    string       name;
    int          sig;
    logic [17:0] val;
  } exp_t;
  exp_t lit_q[$];
  int   lit_rd = 0;
  exp_t cur_e;
  logic [17:0] act;

  function automatic logic [4:0] route_of(input logic [17:0] f);
    int dx, dy;
    dx = int'(f[15:14]);
    dy = int'(f[13:12]);
    if (dx > 1) return 5'b00010;
    if (dx < 1) return 5'b01000;
    if (dy > 1) return 5'b00100;
    if (dy < 1) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [17:0] mk(input logic [1:0] t, input int dx, input int dy, input logic [11:0] lo);
    return {t, 2'(dx), 2'(dy), lo};
  endfunction

  // Outside a packet a head opens one and anything else is stray; inside, everything is forwarded.
  task automatic classify(input logic [17:0] f);
    if (!mdl_in_pkt) begin
      if (f[16]) begin
        mdl_route = route_of(f);
        cls_q.push_back(1'b1);
        route_q.push_back(mdl_route);
        mdl_in_pkt = (f[17:16] != 2'b11);
      end else begin
        cls_q.push_back(1'b0);
        route_q.push_back(5'b0);
      end
    end else begin
      cls_q.push_back(1'b1);
      route_q.push_back(mdl_route);
      if (f[17]) mdl_in_pkt = 1'b0;
    end
  endtask

  task automatic reclassify();
    cls_q.delete();
    route_q.delete();
    mdl_in_pkt = 1'b0;
    foreach (fifo_q[i]) classify(fifo_q[i]);
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 18'($urandom) : fifo_q[0];
  endtask

  task automatic push(input logic [17:0] f);
    fifo_q.push_back(f);
    classify(f);
    drive_fifo();
  endtask

  task automatic expect_lit(input string n, input int s, input logic [17:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    lit_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (pops_done < pop_cnt) begin
      void'(fifo_q.pop_front());
      void'(cls_q.pop_front());
      void'(route_q.pop_front());
      pops_done++;
    end
    if (rst) reclassify();
    drive_fifo();
  endtask

  task automatic gen_packet();
    int nb;
    if ($urandom_range(0, 9) == 0) begin
      gen_q.push_back(mk($urandom_range(0, 1) ? 2'b10 : 2'b00, 0, 0, 12'($urandom)));
    end else if ($urandom_range(0, 3) == 0) begin
      gen_q.push_back(mk(2'b11, $urandom_range(0, 3), $urandom_range(0, 3), 12'($urandom)));
    end else begin
      gen_q.push_back(mk(2'b01, $urandom_range(0, 3), $urandom_range(0, 3), 12'($urandom)));
      nb = $urandom_range(0, 3);
      for (int i = 0; i < nb; i++)
        gen_q.push_back(mk(($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00,
                           $urandom_range(0, 3), $urandom_range(0, 3), 12'($urandom)));
      gen_q.push_back(mk(2'b10, $urandom_range(0, 3), $urandom_range(0, 3), 12'($urandom)));
    end
  endtask

  task automatic check(input string name, input logic [17:0] a, input logic [17:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  // Single compare process: literal expectations first, then the FIFO scoreboard.
  always @(negedge clk) begin
    while (lit_rd < lit_q.size()) begin
      cur_e = lit_q[lit_rd];
      case (cur_e.sig)
        0:       act = 18'(req);
        1:       act = 18'(flit_valid);
        2:       act = flit_out;
        3:       act = 18'(drop_err);
        4:       act = 18'(fifo_read);
        default: act = 18'(fifo_q.size()) + 18'(req);
      endcase
      check(cur_e.name, act, cur_e.val);
      lit_rd++;
    end
    if (rst) begin
      check("rst_quiet", 18'({fifo_read, flit_valid, drop_err}), 18'd0);
    end else if (fifo_read) begin
      if (fifo_empty) begin
        check("pop_when_empty", 18'(fifo_empty), 18'd0);
      end else if (cls_q[0]) begin
        check("fwd_valid",  18'(flit_valid), 18'd1);
        check("fwd_data",   flit_out, fifo_q[0]);
        check("fwd_req",    18'(req), 18'(route_q[0]));
        check("fwd_grant",  18'(|(grant & req)), 18'd1);
        check("fwd_full",   18'(out_full), 18'd0);
        check("fwd_nodrop", 18'(drop_err), 18'd0);
        pop_cnt++;
      end else begin
        check("drop_pulse", 18'(drop_err), 18'd1);
        check("drop_valid", 18'(flit_valid), 18'd0);
        check("drop_req",   18'(req), 18'd0);
        pop_cnt++;
      end
    end else begin
      check("idle_quiet", 18'({flit_valid, drop_err}), 18'd0);
    end
  end

  int          dxs[3]   = '{1, 1, 0};
  int          dys[3]   = '{0, 3, 1};
  logic [4:0]  exp_r[3] = '{5'b00001, 5'b00100, 5'b01000};
  logic [17:0] f_head, f_b1, f_b2, f_tail;
  int          guard;

  initial begin
    rst = 1'b1; grant = '0; out_full = 1'b0;
    drive_fifo();
    step(); step();
    rst = 1'b0;
    expect_lit("reset_req", 0, 18'd0);
    expect_lit("reset_valid", 1, 18'd0);
    expect_lit("reset_flit_out", 2, 18'd0);
    expect_lit("reset_drop", 3, 18'd0);
    expect_lit("reset_read", 4, 18'd0);
    step();

    // head (3,1), body, tail; grant two cycles after req
    f_head = 18'h1D000; f_b1 = 18'h01234; f_tail = 18'h200AB;
    push(f_head); push(f_b1); push(f_tail);
    expect_lit("t1_req_before", 0, 18'd0);
    expect_lit("t1_no_pop", 4, 18'd0);
    step(); expect_lit("t1_req_east", 0, 18'h02);
    step();
    step(); grant = 5'b00010; expect_lit("t1_wait_grant", 1, 18'd0);
    step(); expect_lit("t1_v0", 1, 18'd1); expect_lit("t1_head", 2, 18'h1D000);
    step(); expect_lit("t1_v1", 1, 18'd1); expect_lit("t1_body", 2, 18'h01234);
    step(); expect_lit("t1_v2", 1, 18'd1); expect_lit("t1_tail", 2, 18'h200AB);
    step(); expect_lit("t1_release", 0, 18'd0); expect_lit("t1_gap", 1, 18'd0);
    grant = '0;

    // single-flit packet to local
    step(); push(18'h35000);
    step(); expect_lit("t2_req_local", 0, 18'h10); grant = 5'b10000;
    step(); expect_lit("t2_valid", 1, 18'd1); expect_lit("t2_flit", 2, 18'h35000);
    step(); expect_lit("t2_idle", 0, 18'd0); expect_lit("t2_done", 1, 18'd0); grant = '0;

    for (int i = 0; i < 3; i++) begin
      step(); push(mk(2'b11, dxs[i], dys[i], 12'(i)));
      step(); expect_lit("t3_route", 0, 18'(exp_r[i])); grant = exp_r[i];
      step(); expect_lit("t3_valid", 1, 18'd1);
      step(); grant = '0;
    end

    // 4-cycle out_full stall after the head
    f_b1 = 18'h0AAAA; f_b2 = 18'h05555;
    step(); push(f_head); push(f_b1); push(f_b2); push(f_tail);
    step(); grant = 5'b00010;
    step(); expect_lit("t4_head", 1, 18'd1);
    for (int i = 0; i < 4; i++) begin
      step(); out_full = 1'b1;
      expect_lit("t4_stall_read", 4, 18'd0); expect_lit("t4_stall_valid", 1, 18'd0);
    end
    step(); out_full = 1'b0;
    expect_lit("t4_resume", 1, 18'd1); expect_lit("t4_resume_data", 2, 18'h0AAAA);
    step(); expect_lit("t4_body2", 2, 18'h05555);
    step(); expect_lit("t4_tail", 2, 18'h200AB);
    step(); expect_lit("t4_release", 0, 18'd0); grant = '0;

    // stray body at idle, then a normal head
    step(); push(18'h0BEEF);
    expect_lit("t5_drop", 3, 18'd1); expect_lit("t5_pop", 4, 18'd1); expect_lit("t5_req", 0, 18'd0);
    step(); push(18'h35001); expect_lit("t5_drop_once", 3, 18'd0);
    step(); expect_lit("t5_routed", 0, 18'h10); grant = 5'b10000;
    step(); expect_lit("t5_valid", 1, 18'd1);
    step(); grant = '0;

    // reset in SEND after the head
    step(); push(f_head); push(f_b2); push(f_tail);
    step(); grant = 5'b00010;
    step(); expect_lit("t6_head", 1, 18'd1);
    step(); rst = 1'b1; grant = '0;
    step(); rst = 1'b0;
    expect_lit("t6_req_cleared", 0, 18'd0); expect_lit("t6_drop_body", 3, 18'd1);
    step(); expect_lit("t6_drop_tail", 3, 18'd1);
    step(); expect_lit("t6_quiet", 3, 18'd0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if (gen_q.size() == 0) gen_packet();
      if (fifo_q.size() < 8 && $urandom_range(0, 3) != 0) push(gen_q.pop_front());
      if (req == '0) grant = '0;
      else case ($urandom_range(0, 7))
        0:       grant = '0;
        1:       grant = {req[3:0], req[4]};
        default: grant = req;
      endcase
      out_full = ($urandom_range(0, 3) == 0);
    end

    // drain with grants always given
    guard = 0;
    rst = 1'b0;
    out_full = 1'b0;
    while (guard < 400) begin
      step();
      if (gen_q.size() != 0) push(gen_q.pop_front());
      grant = req;
      if (fifo_q.size() == 0 && req == '0 && gen_q.size() == 0) break;
      guard++;
    end
    expect_lit("drain_complete", 5, 18'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
